// File: rtl/i2c_globals_pkg.sv
// i2c_globals_pkg: shared widths, R/W encoding and target FSM states for the I2C blocks.
package i2c_globals_pkg;
    localparam int DATA_LENGTH = 8;
    localparam int REGISTER_ADDRESS_WIDTH = 8;
    typedef enum logic {WRITE = 1'b0, READ = 1'b1} read_write_e;
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG_PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } i2c_slave_state_e;
endpackage

// File: rtl/i2c_bus_condition_detector.sv
// i2c_bus_condition_detector: synchronizes SCL/SDA into pclk and flags SCL edges, START and STOP.
module i2c_bus_condition_detector (
    input  logic pclk,
    input  logic areset,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop,
    output logic o_sda
);
    logic r_scl_meta, r_scl_sync, r_scl_prev;
    logic r_sda_meta, r_sda_sync, r_sda_prev;

    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            {r_scl_meta, r_scl_sync, r_scl_prev} <= '1;
            {r_sda_meta, r_sda_sync, r_sda_prev} <= '1;
        end else begin
            {r_scl_meta, r_scl_sync, r_scl_prev} <= {i_scl, r_scl_meta, r_scl_sync};
            {r_sda_meta, r_sda_sync, r_sda_prev} <= {i_sda, r_sda_meta, r_sda_sync};
        end
    end

    assign o_scl_rise = r_scl_sync & ~r_scl_prev;
    assign o_scl_fall = ~r_scl_sync & r_scl_prev;
    assign o_start    = r_scl_sync & r_scl_prev & r_sda_prev & ~r_sda_sync;
    assign o_stop     = r_scl_sync & r_scl_prev & ~r_sda_prev & r_sda_sync;
    assign o_sda      = r_sda_sync;
endmodule

// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder: 7-bit I2C target with a register pointer, byte-wide write strobe and
// auto-incrementing reads; no clock stretching.
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDRESS = 7'h68,
    parameter int DATA_LENGTH = 8,
    parameter int REGISTER_ADDRESS_WIDTH = 8
) (
    input  logic                              pclk,
    input  logic                              areset,
    input  logic                              scl_i,
    input  logic                              sda_i,
    output logic                              sda_oen,
    output logic [REGISTER_ADDRESS_WIDTH-1:0] reg_addr,
    output logic                              reg_wr_en,
    output logic [DATA_LENGTH-1:0]            reg_wr_data,
    input  logic [DATA_LENGTH-1:0]            reg_rd_data,
    output logic                              busy,
    output logic                              start_det,
    output logic                              stop_det
);
    import i2c_globals_pkg::*;

    localparam logic [3:0] W8 = 4'(DATA_LENGTH);

    logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda, w_match;
    logic [DATA_LENGTH-1:0] w_byte;
    i2c_slave_state_e r_state;
    read_write_e r_rw;
    logic [3:0] r_bit_cnt;
    logic [DATA_LENGTH-1:0] r_shift;
    logic r_inc;

    i2c_bus_condition_detector u_det (
        .pclk      (pclk),
        .areset    (areset),
        .i_scl     (scl_i),
        .i_sda     (sda_i),
        .o_scl_rise(w_scl_rise),
        .o_scl_fall(w_scl_fall),
        .o_start   (w_start),
        .o_stop    (w_stop),
        .o_sda     (w_sda)
    );

    assign w_byte  = {r_shift[DATA_LENGTH-2:0], w_sda};
    assign w_match = (r_shift[DATA_LENGTH-1:1] == SLAVE_ADDRESS) && (SLAVE_ADDRESS != 7'd0);

    // Bus conditions take priority over every bit-level event.
    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            r_state     <= IDLE;
            r_rw        <= WRITE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_inc       <= 1'b0;
            sda_oen     <= 1'b0;
            reg_addr    <= '0;
            reg_wr_en   <= 1'b0;
            reg_wr_data <= '0;
            busy        <= 1'b0;
            start_det   <= 1'b0;
            stop_det    <= 1'b0;
        end else begin
            reg_wr_en <= 1'b0;
            r_inc     <= 1'b0;
            start_det <= w_start;
            stop_det  <= w_stop;
            if (r_inc) reg_addr <= reg_addr + 1'b1;
            if (w_stop) begin
                r_state   <= IDLE;
                sda_oen   <= 1'b0;
                busy      <= 1'b0;
                r_bit_cnt <= '0;
            end else if (w_start) begin
                r_state   <= ADDR;
                sda_oen   <= 1'b0;
                r_bit_cnt <= '0;
            end else if (w_scl_rise) begin
                if ((r_state inside {ADDR, REG_PTR, WR_DATA, RD_DATA}) && r_bit_cnt < W8) begin
                    r_shift   <= (r_state == RD_DATA) ? r_shift << 1 : w_byte;
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
                if (r_state == WR_DATA && r_bit_cnt == W8 - 1'b1) begin
                    reg_wr_en   <= 1'b1;
                    reg_wr_data <= w_byte;
                    r_inc       <= 1'b1;
                end
                if (r_state == RD_ACK && w_sda) r_state <= IGNORE;
            end else if (w_scl_fall) begin
                case (r_state)
                    ADDR: if (r_bit_cnt == W8) begin
                        r_state <= w_match ? ADDR_ACK : IGNORE;
                        sda_oen <= w_match;
                        busy    <= busy | w_match;
                        r_rw    <= read_write_e'(r_shift[0]);
                    end
                    ADDR_ACK, RD_ACK: begin
                        r_bit_cnt <= '0;
                        if (r_state == ADDR_ACK && r_rw == WRITE) begin
                            sda_oen <= 1'b0;
                            r_state <= REG_PTR;
                        end else begin
                            r_shift  <= reg_rd_data;
                            sda_oen  <= ~reg_rd_data[DATA_LENGTH-1];
                            reg_addr <= reg_addr + 1'b1;
                            r_state  <= RD_DATA;
                        end
                    end
                    REG_PTR: if (r_bit_cnt == W8) begin
                        reg_addr <= REGISTER_ADDRESS_WIDTH'(r_shift);
                        sda_oen  <= 1'b1;
                        r_state  <= PTR_ACK;
                    end
                    WR_DATA: if (r_bit_cnt == W8) begin
                        sda_oen <= 1'b1;
                        r_state <= WR_ACK;
                    end
                    PTR_ACK, WR_ACK: begin
                        sda_oen   <= 1'b0;
                        r_bit_cnt <= '0;
                        r_state   <= WR_DATA;
                    end
                    RD_DATA: begin
                        sda_oen <= (r_bit_cnt == W8) ? 1'b0 : ~r_shift[DATA_LENGTH-1];
                        if (r_bit_cnt == W8) r_state <= RD_ACK;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave_responder.sv
// tb_i2c_slave_responder: bit-banged I2C master, register-file model and write scoreboard.
module tb_i2c_slave_responder;
    localparam logic [6:0] SLV = 7'h68;
    localparam time Q = 50;

    typedef struct {logic [7:0] a; logic [7:0] d;} wr_t;

    logic pclk = 0, areset = 1, scl = 1, m_sda = 1;
    logic sda_bus, sda_oen, reg_wr_en, busy, start_det, stop_det;
    logic [7:0] reg_addr, reg_wr_data, rd_q;
    logic [7:0] dut_mem[256];
    logic [7:0] m_mem[256];
    logic [7:0] m_ptr;
    wr_t exp_wr[$];
    wr_t e_wr;
    int total = 0, bad = 0, n_stop = 0;
    bit seen_oen, seen_busy;

    always #5 pclk = ~pclk;
    assign sda_bus = m_sda & ~sda_oen;

    i2c_slave_responder dut (
        .pclk(pclk), .areset(areset), .scl_i(scl), .sda_i(sda_bus), .sda_oen(sda_oen),
        .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
        .reg_rd_data(rd_q), .busy(busy), .start_det(start_det), .stop_det(stop_det)
    );

    always @(posedge pclk) begin
        rd_q <= dut_mem[reg_addr];
        if (reg_wr_en) dut_mem[reg_addr] <= reg_wr_data;
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", n, got, exp);
        end
    endtask

    always @(negedge pclk) begin
        if (reg_wr_en) begin
            if (exp_wr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h, required none", reg_addr, reg_wr_data);
            end else begin
                e_wr = exp_wr.pop_front();
                chk("wr_addr", reg_addr, e_wr.a);
                chk("wr_data", reg_wr_data, e_wr.d);
            end
        end
        if (stop_det) n_stop++;
        if (sda_oen) seen_oen = 1;
        if (busy) seen_busy = 1;
    end

    task automatic bus_start();
        if (!scl) begin
            m_sda = 1; #Q; scl = 1; #Q;
        end
        m_sda = 0; #Q; scl = 0; #Q;
    endtask

    task automatic bus_stop();
        m_sda = 0; #Q; scl = 1; #Q; m_sda = 1; #(2 * Q);
    endtask

    task automatic wbit(input bit b);
        m_sda = b; #Q; scl = 1; #(2 * Q); scl = 0; #Q;
    endtask

    task automatic rbit(output bit b);
        m_sda = 1; #Q; scl = 1; #Q; b = sda_bus; #Q; scl = 0; #Q;
    endtask

    task automatic wbyte(input logic [7:0] d, output bit ack);
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(ack);
    endtask

    task automatic rbyte(output logic [7:0] d, input bit nack);
        bit b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
        wbit(nack);
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] ptr, input int n,
                            input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        logic [7:0] d[3];
        bit ack, match;
        d = '{d0, d1, d2};
        match = (a == SLV) && (a != 0);
        bus_start();
        wbyte({a, 1'b0}, ack);
        chk("addr_ack", 32'(ack), 32'(!match));
        wbyte(ptr, ack);
        chk("ptr_ack", 32'(ack), 32'(!match));
        if (match) m_ptr = ptr;
        for (int i = 0; i < n; i++) begin
            if (match) begin
                exp_wr.push_back('{m_ptr, d[i]});
                m_mem[m_ptr] = d[i];
                m_ptr++;
            end
            wbyte(d[i], ack);
            chk("data_ack", 32'(ack), 32'(!match));
        end
    endtask

    task automatic do_read(input logic [6:0] a, input int n);
        bit ack, match;
        logic [7:0] d, exp;
        match = (a == SLV) && (a != 0);
        bus_start();
        wbyte({a, 1'b1}, ack);
        chk("rd_addr_ack", 32'(ack), 32'(!match));
        for (int i = 0; i < n; i++) begin
            exp = match ? m_mem[m_ptr] : 8'hFF;
            if (match) m_ptr++;
            rbyte(d, i == n - 1);
            chk("rd_byte", d, exp);
        end
        chk("rel_after_nack", sda_oen, 0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_oen", sda_oen, 0);
        chk("rst_addr", reg_addr, 0);
        chk("rst_wr_en", reg_wr_en, 0);
        chk("rst_wr_data", reg_wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", start_det, 0);
        chk("rst_stop", stop_det, 0);
    endtask

    initial begin
        bit ack;
        int n;
        logic [6:0] a;
        for (int i = 0; i < 256; i++) begin
            m_mem[i] = 8'($urandom);
            dut_mem[i] = m_mem[i];
        end
        m_mem[8'h20] = 8'h5A; dut_mem[8'h20] = 8'h5A;
        m_mem[8'h21] = 8'hC3; dut_mem[8'h21] = 8'hC3;
        m_mem[8'h40] = 8'h2B; dut_mem[8'h40] = 8'h2B;
        m_ptr = 0;
        repeat (3) @(posedge pclk);
        #1 chk_reset_vals();
        @(negedge pclk) areset = 0;
        #(2 * Q);

        n_stop = 0;
        do_write(SLV, 8'h10, 2, 8'hA5, 8'h3C, 8'h00);
        chk("busy_mid", busy, 1);
        bus_stop();
        chk("wr_final_addr", reg_addr, 8'h12);
        chk("busy_after_stop", busy, 0);
        chk("stop_pulses", n_stop, 1);
        chk("wr_pending", exp_wr.size(), 0);

        do_write(SLV, 8'h20, 0, 8'h00, 8'h00, 8'h00);
        do_read(SLV, 2);
        chk("busy_before_stop", busy, 1);
        bus_stop();
        chk("rd_busy_drop", busy, 0);
        chk("rd_final_addr", reg_addr, m_ptr);

        seen_oen = 0;
        seen_busy = 0;
        do_write(7'h50, 8'h33, 2, 8'h77, 8'h88, 8'h00);
        bus_stop();
        chk("miss_oen", seen_oen, 0);
        chk("miss_busy", seen_busy, 0);
        chk("miss_addr", reg_addr, m_ptr);

        do_write(SLV, 8'hFF, 2, 8'h11, 8'h22, 8'h00);
        bus_stop();
        chk("wrap_addr", reg_addr, 8'h01);

        do_write(SLV, 8'h05, 0, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) wbit(1'b1);
        bus_stop();
        chk("abort_busy", busy, 0);
        chk("abort_oen", sda_oen, 0);
        do_write(SLV, 8'h30, 1, 8'($urandom), 8'h00, 8'h00);
        bus_stop();
        chk("post_abort_addr", reg_addr, 8'h31);

        do_write(SLV, 8'h40, 0, 8'h00, 8'h00, 8'h00);
        bus_start();
        wbyte({SLV, 1'b1}, ack);
        chk("rst_rd_ack", 32'(ack), 0);
        #(Q / 2);
        chk("drive_zero", sda_oen, 1);
        #3 areset = 1;
        #1 chk_reset_vals();
        m_ptr = 0;
        @(negedge pclk) areset = 0;
        scl = 1;
        #(2 * Q);
        do_write(SLV, 8'h41, 1, 8'($urandom), 8'h00, 8'h00);
        bus_stop();
        chk("post_rst_addr", reg_addr, 8'h42);

        for (int it = 0; it < 30; it++) begin
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SLV;
            if ($urandom_range(0, 1) == 1) do_read(a, $urandom_range(1, 3));
            else begin
                n = $urandom_range(0, 3);
                do_write(a, 8'($urandom), n, 8'($urandom), 8'($urandom), 8'($urandom));
            end
            if ($urandom_range(0, 3) != 0) begin
                bus_stop();
                chk("rand_addr", reg_addr, m_ptr);
                chk("rand_busy", busy, 0);
            end
        end
        bus_stop();
        #(4 * Q);
        chk("final_pending", exp_wr.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
